romload_stream: RTL and testbench

// - Parametrised successor of the iosys ROM-load data path. The softcore writes 32-bit words over MMIO.
// - Words are buffered in a DEPTH-word FIFO and serialised into OUT_W-bit beats.
// - The downstream core accepts beats with a valid/ready handshake, so back-pressure is supported.
// - Sits between the iosys MMIO decode (data reg 0x0200_0034, ctrl reg 0x0200_0030) and the core's ROM writer.
//

---
 rtl/romload_stream.sv | 205 ++++++++++++++++++++
 tb/tb_romload_stream.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/romload_stream.sv
`default_nettype none
// ============================================================================
// Module      : romload_stream
// Description : MMIO ROM-load data path. 32-bit words are queued in a
//               DEPTH-word FIFO and serialised little-endian into OUT_W-bit
//               beats on a valid/ready stream with a byte-address counter.
//               Optional byte checksum: define ROMLOAD_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module romload_stream #(
    parameter int DEPTH  = 16,
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_ctrl_we,
    input  logic [3:0]        reg_data_we,
    input  logic [31:0]       reg_di,
    output logic [31:0]       reg_do,
    output logic              reg_data_wait,
    output logic [1:0]        rom_loading,
    output logic [OUT_W-1:0]  rom_do,
    output logic              rom_do_valid,
    input  logic              rom_do_ready,
    output logic [ADDR_W-1:0] rom_addr
);

    localparam int             c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             c_LVL_W = c_PTR_W + 1;
    localparam logic [2:0]     c_BPB   = 3'(OUT_W / 8);
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_mode;
    logic [31:0]         r_mem [DEPTH];
    logic [2:0]          r_cnt [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic [31:0]         r_sh_data;
    logic [2:0]          r_bytes;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         w_csum;

    logic       w_start;
    logic       w_full;
    logic       w_empty;
    logic       w_wr_req;
    logic       w_push;
    logic       w_pop;
    logic       w_acc;
    logic       w_last;
    logic       w_ser_free;
    logic       w_done;
    logic [2:0] w_cnt;

    // Any nonzero control write (re)starts a load from a clean slate.
    assign w_start    = reg_ctrl_we && (reg_di[1:0] != 2'd0);
    assign w_full     = (r_level == c_FULL);
    assign w_empty    = (r_level == '0);
    assign w_wr_req   = (r_state == ST_LOAD) && !reg_ctrl_we && (reg_data_we != 4'd0);
    assign w_push     = w_wr_req && !w_full;
    assign w_acc      = rom_do_valid && rom_do_ready;
    assign w_last     = (r_bytes <= c_BPB);
    assign w_ser_free = (r_bytes == 3'd0) || (w_acc && w_last);
    assign w_pop      = !w_empty && w_ser_free;
    assign w_done     = (r_state == ST_DRAIN) && w_empty && w_ser_free;

    always_comb begin
        w_cnt = 3'd4;
        case (reg_data_we)
            4'b0001: w_cnt = 3'd1;
            4'b0011: w_cnt = 3'd2;
            4'b0111: w_cnt = 3'd3;
            default: w_cnt = 3'd4;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start)
                    w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_start)
                    w_state_nxt = ST_LOAD;
                else if (reg_ctrl_we)
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_start)
                    w_state_nxt = ST_LOAD;
                else if (w_done)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Storage has no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= reg_di;
            r_cnt[r_wr_ptr] <= w_cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_mode    <= 2'd0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_sh_data <= 32'd0;
            r_bytes   <= 3'd0;
            r_addr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_mode    <= reg_di[1:0];
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_level   <= '0;
                r_sh_data <= 32'd0;
                r_bytes   <= 3'd0;
                r_addr    <= '0;
            end else begin
                if (w_done)
                    r_mode <= 2'd0;
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                if (w_push && !w_pop)
                    r_level <= r_level + c_LVL_W'(1);
                else if (w_pop && !w_push)
                    r_level <= r_level - c_LVL_W'(1);
                if (w_acc)
                    r_addr <= r_addr + ADDR_W'(c_BPB);
                // Reload on the last accepted beat keeps the stream bubble-free.
                if (w_pop) begin
                    r_sh_data <= r_mem[r_rd_ptr];
                    r_bytes   <= r_cnt[r_rd_ptr];
                end else if (w_acc) begin
                    r_sh_data <= r_sh_data >> OUT_W;
                    r_bytes   <= w_last ? 3'd0 : (r_bytes - c_BPB);
                end
            end
        end
    end

    generate
        if (OUT_W == 16) begin : g_out16
            assign rom_do = (r_bytes == 3'd1) ? {8'h00, r_sh_data[7:0]} : r_sh_data[15:0];
        end else begin : g_out8
            assign rom_do = r_sh_data[7:0];
        end
    endgenerate

`ifdef ROMLOAD_CHECKSUM_EN
    logic [15:0] r_csum;
    logic [15:0] w_beat_sum;

    generate
        if (OUT_W == 16) begin : g_sum16
            assign w_beat_sum = {8'h00, r_sh_data[7:0]}
                              + ((r_bytes == 3'd1) ? 16'h0000 : {8'h00, r_sh_data[15:8]});
        end else begin : g_sum8
            assign w_beat_sum = {8'h00, r_sh_data[7:0]};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_csum <= 16'd0;
        else if (w_start)
            r_csum <= 16'd0;
        else if (w_acc)
            r_csum <= r_csum + w_beat_sum;
    end

    assign w_csum = r_csum;
`else
    assign w_csum = 16'd0;
`endif

    assign rom_do_valid  = (r_bytes != 3'd0);
    assign rom_addr      = r_addr;
    assign rom_loading   = r_mode;
    assign reg_data_wait = w_wr_req && w_full;
    assign reg_do        = {r_state, 6'b0, 8'(r_level), w_csum};

endmodule
`default_nettype wire

// File: tb/tb_romload_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_romload_stream
// Description : Directed self-checking bench for romload_stream
//               (8-bit and 16-bit beat instances, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_romload_stream;

    logic clk = 1'b0;
    logic reset;

    logic        a_ctrl_we;
    logic [3:0]  a_data_we;
    logic [31:0] a_di;
    logic [31:0] a_do;
    logic        a_wait;
    logic [1:0]  a_loading;
    logic [7:0]  a_rom_do;
    logic        a_valid;
    logic        a_ready;
    logic [22:0] a_addr;

    logic        b_ctrl_we;
    logic [3:0]  b_data_we;
    logic [31:0] b_di;
    logic [31:0] b_do;
    logic        b_wait;
    logic [1:0]  b_loading;
    logic [15:0] b_rom_do;
    logic        b_valid;
    logic        b_ready;
    logic [22:0] b_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    logic pend, acc, early, stale;
    logic [31:0] addr_exp;
    logic [7:0]  base;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    romload_stream #(.DEPTH(4), .OUT_W(8), .ADDR_W(23)) u_dut8 (
        .clk(clk), .reset(reset), .reg_ctrl_we(a_ctrl_we), .reg_data_we(a_data_we),
        .reg_di(a_di), .reg_do(a_do), .reg_data_wait(a_wait), .rom_loading(a_loading),
        .rom_do(a_rom_do), .rom_do_valid(a_valid), .rom_do_ready(a_ready), .rom_addr(a_addr)
    );

    romload_stream #(.DEPTH(4), .OUT_W(16), .ADDR_W(23)) u_dut16 (
        .clk(clk), .reset(reset), .reg_ctrl_we(b_ctrl_we), .reg_data_we(b_data_we),
        .reg_di(b_di), .reg_do(b_do), .reg_data_wait(b_wait), .rom_loading(b_loading),
        .rom_do(b_rom_do), .rom_do_valid(b_valid), .rom_do_ready(b_ready), .rom_addr(b_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [31:0] w, input logic [3:0] s);
        a_data_we = s;
        a_di      = w;
        step();
        a_data_we = 4'h0;
    endtask

    task automatic a_ctrl(input logic [1:0] m);
        a_ctrl_we = 1'b1;
        a_di      = {30'd0, m};
        step();
        a_ctrl_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        a_ctrl_we = 1'b0; a_data_we = 4'h0; a_di = 32'd0; a_ready = 1'b0;
        b_ctrl_we = 1'b0; b_data_we = 4'h0; b_di = 32'd0; b_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;

        // Reset state
        chk("rst_reg_do",  a_do, 32'h0);
        chk("rst_loading", 32'(a_loading), 32'h0);
        chk("rst_valid",   32'(a_valid), 32'h0);
        chk("rst_rom_do",  32'(a_rom_do), 32'h0);
        chk("rst_addr",    32'(a_addr), 32'h0);
        chk("rst_wait",    32'(a_wait), 32'h0);
        chk("rst_b_do",    b_do, 32'h0);

        // Data writes in IDLE are dropped
        a_write(32'hDEADBEEF, 4'hF);
        chk("idle_drop_level", 32'(a_do[23:16]), 32'h0);
        chk("idle_state",      32'(a_do[31:30]), 32'h0);

        // Basic load: 4 beats, first valid two clocks after the write
        a_ctrl(2'd1);
        chk("load_state",   32'(a_do[31:30]), 32'h1);
        chk("load_loading", 32'(a_loading), 32'h1);
        a_ready = 1'b1;
        a_write(32'h44332211, 4'hF);
        chk("lat_level1", 32'(a_do[23:16]), 32'h1);
        chk("lat_valid0", 32'(a_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("basic_valid", 32'(a_valid), 32'h1);
            chk("basic_beat",  32'(a_rom_do), 32'h11 * (i + 1));
            chk("basic_addr",  32'(a_addr), 32'(i));
        end
        step();
        chk("basic_end_valid", 32'(a_valid), 32'h0);
        chk("basic_end_addr",  32'(a_addr), 32'h4);

        // Back-pressure: serialiser preloaded, then four words fill the FIFO
        a_ready = 1'b0;
        a_write(32'hA3A2A1A0, 4'hF);
        step();
        chk("bp_pre_valid", 32'(a_valid), 32'h1);
        chk("bp_pre_beat",  32'(a_rom_do), 32'hA0);
        step();
        chk("bp_hold_beat", 32'(a_rom_do), 32'hA0);
        chk("bp_hold_addr", 32'(a_addr), 32'h4);
        for (int i = 0; i < 4; i++) begin
            base = 8'hB0 + 8'(i * 16);
            a_write({base + 8'd3, base + 8'd2, base + 8'd1, base}, 4'hF);
            chk("bp_fill_level", 32'(a_do[23:16]), 32'(i + 1));
        end
        a_data_we = 4'b0011;
        a_di      = 32'hF3F2F1F0;
        #1;
        chk("bp_wait_on", 32'(a_wait), 32'h1);
        step();
        chk("bp_wait_held", 32'(a_wait), 32'h1);
        chk("bp_full_level", 32'(a_do[23:16]), 32'h4);

        exp_q.delete();
        for (int w = 0; w < 5; w++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'hA0 + 8'(w * 16 + b));
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'hF1);
        addr_exp = 32'h4;
        pend = 1'b1;
        cyc  = 0;
        while (exp_q.size() != 0 && cyc < 60) begin
            a_ready = 1'b1;
            #1;
            if (a_valid) begin
                chk("bp_beat", 32'(a_rom_do), 32'(exp_q[0]));
                chk("bp_addr", 32'(a_addr), addr_exp);
                void'(exp_q.pop_front());
                addr_exp = addr_exp + 32'd1;
            end
            acc = pend && !a_wait;
            step();
            cyc++;
            if (acc) begin
                a_data_we = 4'h0;
                pend = 1'b0;
            end
        end
        chk("bp_cycles",   32'(cyc), 32'd22);
        chk("bp_accepted", 32'(pend), 32'h0);
        chk("bp_end_valid", 32'(a_valid), 32'h0);
        chk("bp_end_addr",  32'(a_addr), 32'd26);
        chk("bp_end_level", 32'(a_do[23:16]), 32'h0);

        // Drain with 3 words queued and ready toggling
        a_ready = 1'b0;
        a_write(32'h00005150, 4'b0011);
        a_write(32'h00000060, 4'b0001);
        a_write(32'h00727170, 4'b0111);
        chk("dr_level", 32'(a_do[23:16]), 32'h2);
        chk("dr_beat0", 32'(a_rom_do), 32'h50);
        a_ctrl(2'd0);
        chk("dr_state",   32'(a_do[31:30]), 32'h2);
        chk("dr_loading", 32'(a_loading), 32'h1);
        a_write(32'h12345678, 4'hF);
        chk("dr_drop_level", 32'(a_do[23:16]), 32'h2);
        exp_q = '{8'h50, 8'h51, 8'h60, 8'h70, 8'h71, 8'h72};
        addr_exp = 32'd26;
        early = 1'b0;
        cyc   = 0;
        while (exp_q.size() != 0 && cyc < 40) begin
            a_ready = cyc[0];
            #1;
            if (a_loading == 2'd0)
                early = 1'b1;
            if (a_valid && a_ready) begin
                chk("dr_beat", 32'(a_rom_do), 32'(exp_q[0]));
                chk("dr_addr", 32'(a_addr), addr_exp);
                void'(exp_q.pop_front());
                addr_exp = addr_exp + 32'd1;
            end
            step();
            cyc++;
        end
        a_ready = 1'b0;
        chk("dr_all_beats",   32'(exp_q.size()), 32'h0);
        chk("dr_no_early",    32'(early), 32'h0);
        chk("dr_loading_off", 32'(a_loading), 32'h0);
        chk("dr_idle",        32'(a_do[31:30]), 32'h0);

        // Restart during LOAD flushes queued words
        a_ctrl(2'd1);
        chk("rs_addr_clr", 32'(a_addr), 32'h0);
        a_write(32'h03020100, 4'hF);
        a_write(32'h13121110, 4'hF);
        a_write(32'h23222120, 4'hF);
        chk("rs_level2", 32'(a_do[23:16]), 32'h2);
        chk("rs_valid1", 32'(a_valid), 32'h1);
        a_ctrl(2'd2);
        chk("rs_loading", 32'(a_loading), 32'h2);
        chk("rs_level0",  32'(a_do[23:16]), 32'h0);
        chk("rs_valid0",  32'(a_valid), 32'h0);
        chk("rs_state",   32'(a_do[31:30]), 32'h1);
        a_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (a_valid)
                stale = 1'b1;
        end
        chk("rs_no_stale", 32'(stale), 32'h0);
        a_write(32'h0000005A, 4'b0001);
        step();
        chk("rs_new_beat", 32'(a_rom_do), 32'h5A);
        chk("rs_new_addr", 32'(a_addr), 32'h0);
        step();
        chk("rs_new_done", 32'(a_valid), 32'h0);
        chk("rs_new_addr1", 32'(a_addr), 32'h1);
`ifdef ROMLOAD_CHECKSUM_EN
        chk("rs_csum", 32'(a_do[15:0]), 32'h005A);
`else
        chk("rs_csum", 32'(a_do[15:0]), 32'h0000);
`endif

        // Simultaneous ctrl and data write: ctrl wins, word dropped
        a_ctrl_we = 1'b1;
        a_data_we = 4'hF;
        a_di      = 32'h00000003;
        #1;
        chk("sim_wait", 32'(a_wait), 32'h0);
        step();
        a_ctrl_we = 1'b0;
        a_data_we = 4'h0;
        chk("sim_loading", 32'(a_loading), 32'h3);
        chk("sim_level",   32'(a_do[23:16]), 32'h0);
        chk("sim_addr",    32'(a_addr), 32'h0);
        step();
        chk("sim_no_beat", 32'(a_valid), 32'h0);

        // Asynchronous reset mid-beat
        a_ready = 1'b0;
        a_write(32'h0000C5C4, 4'b0011);
        step();
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        #1;
        chk("ar_pre_valid", 32'(a_valid), 32'h1);
        chk("ar_pre_beat",  32'(a_rom_do), 32'hC5);
        chk("ar_pre_addr",  32'(a_addr), 32'h1);
        reset = 1'b1;
        #1;
        chk("ar_valid",   32'(a_valid), 32'h0);
        chk("ar_rom_do",  32'(a_rom_do), 32'h0);
        chk("ar_addr",    32'(a_addr), 32'h0);
        chk("ar_loading", 32'(a_loading), 32'h0);
        chk("ar_reg_do",  a_do, 32'h0);
        step();
        reset = 1'b0;
        a_ctrl(2'd1);
        a_ready = 1'b1;
        a_write(32'h000000D1, 4'b0001);
        step();
        chk("ar_next_beat", 32'(a_rom_do), 32'hD1);
        chk("ar_next_addr", 32'(a_addr), 32'h0);

        // 16-bit beats with an odd tail byte
        b_ctrl_we = 1'b1;
        b_di      = 32'h00000001;
        step();
        b_ctrl_we = 1'b0;
        chk("w16_loading", 32'(b_loading), 32'h1);
        b_ready   = 1'b1;
        b_data_we = 4'b0111;
        b_di      = 32'hCCBBAA99;
        step();
        b_data_we = 4'h0;
        chk("w16_level", 32'(b_do[23:16]), 32'h1);
        chk("w16_wait",  32'(b_wait), 32'h0);
        step();
        chk("w16_valid0", 32'(b_valid), 32'h1);
        chk("w16_beat0",  32'(b_rom_do), 32'hAA99);
        chk("w16_addr0",  32'(b_addr), 32'h0);
        step();
        chk("w16_beat1",  32'(b_rom_do), 32'h00BB);
        chk("w16_addr1",  32'(b_addr), 32'h2);
        step();
        chk("w16_done",   32'(b_valid), 32'h0);
        chk("w16_addr2",  32'(b_addr), 32'h4);
`ifdef ROMLOAD_CHECKSUM_EN
        chk("w16_csum", 32'(b_do[15:0]), 32'h01FE);
`else
        chk("w16_csum", 32'(b_do[15:0]), 32'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
